rv32i_decode_exec: RTL and testbench
====================================

RV32I_DECODE_EXEC -- requirements
Module: rv32i_decode_exec

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have inputs i_instr[31:0] (instruction), i_pc[31:0] (current PC), i_rs1_data[31:0], i_rs2_data[31:0] (register reads), i_imm[31:0] (pre-generated immediate).
REQ-004 SHALL have outputs o_pc_sel[1:0] (00 PC+4, 01 branch target, 10 JAL target, 11 JALR target), o_rd_wren, o_br_un, o_opa_sel (0 rs1, 1 PC), o_opb_sel[1:0] (00 rs2, 01 imm, 10 const 4), o_alu_op[3:0], o_mem_wren, o_wb_sel[1:0] (00 ALU, 01 load data, 10 PC+4), o_insn_vld.
REQ-005 SHALL have outputs o_br_equal, o_br_less (comparator), o_alu_y[31:0] (ALU result), o_instret[31:0] (valid-instruction counter).

Function
REQ-006 o_alu_op encoding SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B; codes 11-15 SHALL yield 0.
REQ-007 ALU operand A SHALL be i_pc if o_opa_sel else i_rs1_data; operand B per o_opb_sel (11 treated as const 4); o_alu_y combinational from them.
REQ-008 ALU arithmetic SHALL be modulo 2^32; shifts use B[4:0] only; SRA sign-fills; SLT signed, SLTU unsigned, result 0/1 zero-extended.
REQ-009 o_br_equal SHALL be (rs1==rs2); o_br_less SHALL be rs1<rs2 unsigned when o_br_un=1, signed otherwise.
REQ-010 Decode by opcode i_instr[6:0], funct3 [14:12], funct7 [31:25]; unlisted outputs 0; all combinational.
REQ-011 OP 0110011 (funct7 0000000 or 0100000 only with ADD/SUB, SRL/SRA): rd_wren=1, opb=00, wb=00, alu from funct3/funct7[5].
REQ-012 OP-IMM 0010011: rd_wren=1, opb=01, wb=00; SLLI needs funct7=0000000, SRLI/SRAI need 0000000/0100000; no SUBI.
REQ-013 LOAD 0000011 (funct3 000,001,010,100,101): ADD, opb=01, rd_wren=1, wb=01.
REQ-014 STORE 0100011 (funct3 000,001,010): ADD, opb=01, mem_wren=1, rd_wren=0.
REQ-015 BRANCH 1100011 (funct3 000,001,100,101,110,111): opa=1, opb=01, ADD, br_un=funct3[1]; pc_sel=01 iff condition (BEQ eq, BNE !eq, BLT/BLTU less, BGE/BGEU !less) holds, else 00.
REQ-016 JAL 1101111: opa=1, opb=01, ADD, rd_wren=1, wb=10, pc_sel=10. JALR 1100111 funct3=000: opa=0, opb=01, ADD, rd_wren=1, wb=10, pc_sel=11.
REQ-017 LUI 0110111: opb=01, PASS_B, rd_wren=1, wb=00. AUIPC 0010111: opa=1, opb=01, ADD, rd_wren=1, wb=00.
REQ-018 Any encoding above SHALL assert o_insn_vld=1; any other (incl. illegal funct3/funct7) SHALL give o_insn_vld=0, rd_wren=0, mem_wren=0, pc_sel=00.
REQ-019 o_instret SHALL increment by 1 on each rising edge where i_rst_n=1 and o_insn_vld=1; wraps 0xFFFFFFFF->0.

Reset
REQ-020 While i_rst_n=0 all control outputs SHALL be forced to the invalid-instruction values of REQ-018 (o_insn_vld=0, writes 0, pc_sel=00), combinationally.
REQ-021 Rising edge with i_rst_n=0 SHALL clear o_instret to 0, overriding any increment; ALU/comparator outputs remain functional during reset.

Verification
REQ-022 ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=0xFFFFFFFF -> alu_op=0, o_alu_y=4, rd_wren=1, insn_vld=1, instret +1 next edge.
REQ-023 SRAI imm (0x4041D193), rs1=0x80000000, i_imm=0x404 -> alu_op=7, o_alu_y=0xF8000000.
REQ-024 BLT (0x0020C463), rs1=0xFFFFFFFF, rs2=1 -> br_less=1, pc_sel=01; BLTU (0x0020E463) same data -> br_un=1, br_less=0, pc_sel=00.
REQ-025 SW (0x0020A223) -> mem_wren=1, rd_wren=0; JALR (0x000080E7) -> pc_sel=11, wb_sel=10.
REQ-026 0xFFFFFFFF instruction -> insn_vld=0, no writes, instret unchanged; i_rst_n=0 with valid ADD -> insn_vld=0, instret=0 after edge.

Source files
------------

// File: rtl/rv32i_decode_exec.sv
// rv32i_decode_exec
//   Single-cycle RV32I decoder plus ALU and branch comparator. Every control
//   output, the comparator and the ALU result are combinational from the
//   current inputs. The only state is the retired-instruction counter.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous, active-low reset
//   i_instr      instruction word
//   i_pc         PC of the instruction
//   i_rs1_data   register file read port 1
//   i_rs2_data   register file read port 2
//   i_imm        immediate, already generated for the instruction format
//   o_pc_sel     00 PC+4, 01 branch target, 10 JAL target, 11 JALR target
//   o_rd_wren    register file write enable
//   o_br_un      comparator unsigned mode
//   o_opa_sel    ALU A: 0 rs1, 1 PC
//   o_opb_sel    ALU B: 00 rs2, 01 imm, 10/11 const 4
//   o_alu_op     ALU operation code
//   o_mem_wren   data memory write enable
//   o_wb_sel     write-back source: 00 ALU, 01 load data, 10 PC+4
//   o_insn_vld   instruction is a legal RV32I encoding handled here
//   o_br_equal   rs1 == rs2
//   o_br_less    rs1 < rs2 (signed, or unsigned when o_br_un)
//   o_alu_y      ALU result
//   o_instret    count of valid instructions retired

module rv32i_decode_exec #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [DATA_W-1:0] i_imm,
  output logic [1:0]        o_pc_sel,
  output logic              o_rd_wren,
  output logic              o_br_un,
  output logic              o_opa_sel,
  output logic [1:0]        o_opb_sel,
  output logic [3:0]        o_alu_op,
  output logic              o_mem_wren,
  output logic [1:0]        o_wb_sel,
  output logic              o_insn_vld,
  output logic              o_br_equal,
  output logic              o_br_less,
  output logic [DATA_W-1:0] o_alu_y,
  output logic [31:0]       o_instret
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [1:0] OPB_RS2 = 2'b00;
  localparam logic [1:0] OPB_IMM = 2'b01;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  // Maps funct3 (and the SUB/SRA alternate bit) onto the ALU code.
  // Legality of the alternate bit is checked by the caller.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Modulo-2^DATA_W ALU; shift amount is the low five bits of B.
  function automatic logic [DATA_W-1:0] alu_fn(input logic [3:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic [4:0]               sh;
    logic [DATA_W-1:0]        y;
    a_s = a;
    b_s = b;
    sh  = b[4:0];
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << sh;
      ALU_SLT:    y = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU:   y = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> sh;
      ALU_SRA:    y = a_s >>> sh;
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
    return y;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];

  // Register-index fields are consumed by the register file, not here.
  logic unused_instr_fields;
  assign unused_instr_fields = ^{i_instr[24:15], i_instr[11:7]};

  logic       dec_vld;
  logic       dec_rd_wren;
  logic       dec_mem_wren;
  logic       dec_br_un;
  logic       dec_opa_sel;
  logic [1:0] dec_opb_sel;
  logic [3:0] dec_alu_op;
  logic [1:0] dec_wb_sel;
  logic [1:0] dec_pc_sel;
  logic       dec_is_branch;

  // Raw decode; every field stays zero unless the encoding is legal.
  always_comb begin
    dec_vld       = 1'b0;
    dec_rd_wren   = 1'b0;
    dec_mem_wren  = 1'b0;
    dec_br_un     = 1'b0;
    dec_opa_sel   = 1'b0;
    dec_opb_sel   = OPB_RS2;
    dec_alu_op    = ALU_ADD;
    dec_wb_sel    = WB_ALU;
    dec_pc_sel    = PC_PLUS4;
    dec_is_branch = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec_vld     = 1'b1;
          dec_rd_wren = 1'b1;
          dec_alu_op  = alu_from_f3(funct3, funct7[5]);
        end
      end
      OPC_OP_IMM: begin
        // Only the shifts constrain funct7; the other funct3 carry imm bits there.
        if ((funct3 == 3'b001 && funct7 == F7_BASE) ||
            (funct3 == 3'b101 && (funct7 == F7_BASE || funct7 == F7_ALT)) ||
            (funct3 != 3'b001 && funct3 != 3'b101)) begin
          dec_vld     = 1'b1;
          dec_rd_wren = 1'b1;
          dec_opb_sel = OPB_IMM;
          dec_alu_op  = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        end
      end
      OPC_LOAD: begin
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
            funct3 == 3'b100 || funct3 == 3'b101) begin
          dec_vld     = 1'b1;
          dec_rd_wren = 1'b1;
          dec_opb_sel = OPB_IMM;
          dec_wb_sel  = WB_LOAD;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
          dec_vld      = 1'b1;
          dec_mem_wren = 1'b1;
          dec_opb_sel  = OPB_IMM;
        end
      end
      OPC_BRANCH: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          dec_vld       = 1'b1;
          dec_is_branch = 1'b1;
          dec_opa_sel   = 1'b1;
          dec_opb_sel   = OPB_IMM;
          dec_br_un     = funct3[1];
        end
      end
      OPC_JAL: begin
        dec_vld     = 1'b1;
        dec_rd_wren = 1'b1;
        dec_opa_sel = 1'b1;
        dec_opb_sel = OPB_IMM;
        dec_wb_sel  = WB_PC4;
        dec_pc_sel  = PC_JAL;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          dec_vld     = 1'b1;
          dec_rd_wren = 1'b1;
          dec_opb_sel = OPB_IMM;
          dec_wb_sel  = WB_PC4;
          dec_pc_sel  = PC_JALR;
        end
      end
      OPC_LUI: begin
        dec_vld     = 1'b1;
        dec_rd_wren = 1'b1;
        dec_opb_sel = OPB_IMM;
        dec_alu_op  = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        dec_vld     = 1'b1;
        dec_rd_wren = 1'b1;
        dec_opa_sel = 1'b1;
        dec_opb_sel = OPB_IMM;
      end
      default: begin
        dec_vld = 1'b0;
      end
    endcase
  end

  // Reset masks the control outputs so nothing is written while held.
  assign o_insn_vld = i_rst_n & dec_vld;
  assign o_rd_wren  = i_rst_n & dec_rd_wren;
  assign o_mem_wren = i_rst_n & dec_mem_wren;
  assign o_br_un    = i_rst_n & dec_br_un;
  assign o_opa_sel  = i_rst_n & dec_opa_sel;
  assign o_opb_sel  = i_rst_n ? dec_opb_sel : OPB_RS2;
  assign o_alu_op   = i_rst_n ? dec_alu_op  : ALU_ADD;
  assign o_wb_sel   = i_rst_n ? dec_wb_sel  : WB_ALU;

  logic signed [DATA_W-1:0] rs1_s;
  logic signed [DATA_W-1:0] rs2_s;

  assign rs1_s      = i_rs1_data;
  assign rs2_s      = i_rs2_data;
  assign o_br_equal = (i_rs1_data == i_rs2_data);
  assign o_br_less  = o_br_un ? (i_rs1_data < i_rs2_data) : (rs1_s < rs2_s);

  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = o_br_equal;
      3'b001:  br_taken = ~o_br_equal;
      3'b100,
      3'b110:  br_taken = o_br_less;
      3'b101,
      3'b111:  br_taken = ~o_br_less;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    o_pc_sel = PC_PLUS4;
    if (i_rst_n) begin
      if (dec_is_branch) o_pc_sel = br_taken ? PC_BRANCH : PC_PLUS4;
      else               o_pc_sel = dec_pc_sel;
    end
  end

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;

  assign alu_a = o_opa_sel ? i_pc : i_rs1_data;

  always_comb begin
    case (o_opb_sel)
      OPB_RS2: alu_b = i_rs2_data;
      OPB_IMM: alu_b = i_imm;
      default: alu_b = DATA_W'(4);
    endcase
  end

  assign o_alu_y = alu_fn(o_alu_op, alu_a, alu_b);

  // Retire counter: reset wins over an increment on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)        o_instret <= '0;
    else if (o_insn_vld) o_instret <= o_instret + 32'd1;
  end

endmodule

// File: tb/tb_rv32i_decode_exec.sv
module tb_rv32i_decode_exec;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_instr = 32'h0;
  logic [31:0] i_pc = 32'h0;
  logic [31:0] i_rs1_data = 32'h0;
  logic [31:0] i_rs2_data = 32'h0;
  logic [31:0] i_imm = 32'h0;
  logic [1:0]  o_pc_sel;
  logic        o_rd_wren;
  logic        o_br_un;
  logic        o_opa_sel;
  logic [1:0]  o_opb_sel;
  logic [3:0]  o_alu_op;
  logic        o_mem_wren;
  logic [1:0]  o_wb_sel;
  logic        o_insn_vld;
  logic        o_br_equal;
  logic        o_br_less;
  logic [31:0] o_alu_y;
  logic [31:0] o_instret;

  rv32i_decode_exec dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_instr    (i_instr),
    .i_pc       (i_pc),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_imm      (i_imm),
    .o_pc_sel   (o_pc_sel),
    .o_rd_wren  (o_rd_wren),
    .o_br_un    (o_br_un),
    .o_opa_sel  (o_opa_sel),
    .o_opb_sel  (o_opb_sel),
    .o_alu_op   (o_alu_op),
    .o_mem_wren (o_mem_wren),
    .o_wb_sel   (o_wb_sel),
    .o_insn_vld (o_insn_vld),
    .o_br_equal (o_br_equal),
    .o_br_less  (o_br_less),
    .o_alu_y    (o_alu_y),
    .o_instret  (o_instret)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        vld;
    logic        rd;
    logic        mem;
    logic [1:0]  pc_sel;
    logic [1:0]  wb;
    logic        opa;
    logic [1:0]  opb;
    logic [3:0]  alu;
    logic        br_un;
    logic        eq;
    logic        less;
    logic [31:0] y;
    logic [31:0] instret;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          vec_id = 0;
  logic [31:0] exp_cnt = 32'h0;

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s actual=%h required=%h", id, name, act, req);
    end
  endtask

  // Applies one vector just after a rising edge and queues its expectation.
  // The instret model advances for the edge that ends this vector.
  task automatic issue(input logic rst_v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input exp_t e_in);
    exp_t e;
    @(posedge i_clk);
    #1;
    i_rst_n    = rst_v;
    i_instr    = instr;
    i_pc       = pc;
    i_rs1_data = rs1;
    i_rs2_data = rs2;
    i_imm      = imm;
    e          = e_in;
    e.instret  = exp_cnt;
    sb_q.push_back(e);
    if (!rst_v)     exp_cnt = 32'h0;
    else if (e.vld) exp_cnt = exp_cnt + 32'd1;
  endtask

  // Monitor: outputs are combinational, so each queued vector is checked
  // at the falling edge in the middle of its cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        cmp("insn_vld", vec_id, 32'(o_insn_vld), 32'(e.vld));
        cmp("rd_wren",  vec_id, 32'(o_rd_wren),  32'(e.rd));
        cmp("mem_wren", vec_id, 32'(o_mem_wren), 32'(e.mem));
        cmp("pc_sel",   vec_id, 32'(o_pc_sel),   32'(e.pc_sel));
        cmp("wb_sel",   vec_id, 32'(o_wb_sel),   32'(e.wb));
        cmp("opa_sel",  vec_id, 32'(o_opa_sel),  32'(e.opa));
        cmp("opb_sel",  vec_id, 32'(o_opb_sel),  32'(e.opb));
        cmp("alu_op",   vec_id, 32'(o_alu_op),   32'(e.alu));
        cmp("br_un",    vec_id, 32'(o_br_un),    32'(e.br_un));
        cmp("br_equal", vec_id, 32'(o_br_equal), 32'(e.eq));
        cmp("br_less",  vec_id, 32'(o_br_less),  32'(e.less));
        cmp("alu_y",    vec_id, o_alu_y,         e.y);
        cmp("instret",  vec_id, o_instret,       e.instret);
        vec_id++;
      end
    end
  end

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SRAI  = 32'h4041D193;
  localparam logic [31:0] I_BLT   = 32'h0020C463;
  localparam logic [31:0] I_BLTU  = 32'h0020E463;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BGE   = 32'h0020D463;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_BADSL = 32'h402091B3;
  localparam logic [31:0] I_LUI   = 32'h12345137;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_LW    = 32'h0000A103;

  initial begin : stim
    int waited;
    // fields: vld rd mem pc_sel wb opa opb alu br_un eq less y instret(filled by model)
    // Reset held with a valid ADD: control masked, ALU still adds rs1+rs2.
    issue(1'b0, I_ADD,   32'h000, 32'h5,        32'hFFFFFFFF, 32'h0,
          '{1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,4'd0,1'b0,1'b0,1'b0,32'h4,32'h0});
    issue(1'b1, I_ADD,   32'h100, 32'h5,        32'hFFFFFFFF, 32'h0,
          '{1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,4'd0,1'b0,1'b0,1'b0,32'h4,32'h0});
    issue(1'b1, I_SRAI,  32'h104, 32'h80000000, 32'h0,        32'h404,
          '{1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,2'b01,4'd7,1'b0,1'b0,1'b1,32'hF8000000,32'h0});
    issue(1'b1, I_BLT,   32'h200, 32'hFFFFFFFF, 32'h1,        32'h8,
          '{1'b1,1'b0,1'b0,2'b01,2'b00,1'b1,2'b01,4'd0,1'b0,1'b0,1'b1,32'h208,32'h0});
    issue(1'b1, I_BLTU,  32'h200, 32'hFFFFFFFF, 32'h1,        32'h8,
          '{1'b1,1'b0,1'b0,2'b00,2'b00,1'b1,2'b01,4'd0,1'b1,1'b0,1'b0,32'h208,32'h0});
    issue(1'b1, I_SW,    32'h300, 32'h1000,     32'h55,       32'h4,
          '{1'b1,1'b0,1'b1,2'b00,2'b00,1'b0,2'b01,4'd0,1'b0,1'b0,1'b0,32'h1004,32'h0});
    issue(1'b1, I_JALR,  32'h400, 32'h2000,     32'h0,        32'h10,
          '{1'b1,1'b1,1'b0,2'b11,2'b10,1'b0,2'b01,4'd0,1'b0,1'b0,1'b0,32'h2010,32'h0});
    issue(1'b1, I_ILL,   32'h500, 32'h7,        32'h7,        32'h0,
          '{1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,4'd0,1'b0,1'b1,1'b0,32'hE,32'h0});
    issue(1'b1, I_BEQ,   32'h600, 32'h1234,     32'h1234,     32'h20,
          '{1'b1,1'b0,1'b0,2'b01,2'b00,1'b1,2'b01,4'd0,1'b0,1'b1,1'b0,32'h620,32'h0});
    issue(1'b1, I_BGE,   32'h700, 32'h3,        32'hFFFFFFFE, 32'h10,
          '{1'b1,1'b0,1'b0,2'b01,2'b00,1'b1,2'b01,4'd0,1'b0,1'b0,1'b0,32'h710,32'h0});
    issue(1'b1, I_SUB,   32'h800, 32'h5,        32'h7,        32'h0,
          '{1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,4'd1,1'b0,1'b0,1'b1,32'hFFFFFFFE,32'h0});
    // SLL with funct7=0100000 is not a legal encoding.
    issue(1'b1, I_BADSL, 32'h804, 32'h1,        32'h2,        32'h0,
          '{1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,4'd0,1'b0,1'b0,1'b1,32'h3,32'h0});
    issue(1'b1, I_LUI,   32'h808, 32'hAAAA,     32'h0,        32'h12345000,
          '{1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,2'b01,4'd10,1'b0,1'b0,1'b0,32'h12345000,32'h0});
    issue(1'b1, I_AUIPC, 32'h900, 32'h0,        32'h0,        32'h1000,
          '{1'b1,1'b1,1'b0,2'b00,2'b00,1'b1,2'b01,4'd0,1'b0,1'b1,1'b0,32'h1900,32'h0});
    issue(1'b1, I_JAL,   32'hA00, 32'h0,        32'h0,        32'h8,
          '{1'b1,1'b1,1'b0,2'b10,2'b10,1'b1,2'b01,4'd0,1'b0,1'b1,1'b0,32'hA08,32'h0});
    issue(1'b1, I_LW,    32'hA04, 32'h100,      32'h0,        32'hFFFFFFFC,
          '{1'b1,1'b1,1'b0,2'b00,2'b01,1'b0,2'b01,4'd0,1'b0,1'b0,1'b0,32'hFC,32'h0});
    // Mid-run reset with a valid ADD: counter must clear, not increment.
    issue(1'b0, I_ADD,   32'hA08, 32'h5,        32'hFFFFFFFF, 32'h0,
          '{1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,4'd0,1'b0,1'b0,1'b0,32'h4,32'h0});
    issue(1'b1, I_ILL,   32'hA0C, 32'h0,        32'h0,        32'h0,
          '{1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,4'd0,1'b0,1'b1,1'b0,32'h0,32'h0});
    issue(1'b1, I_ADD,   32'hA10, 32'h1,        32'h1,        32'h0,
          '{1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,4'd0,1'b0,1'b1,1'b0,32'h2,32'h0});

    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      @(posedge i_clk);
      waited++;
    end
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
